jtframe_rst_seq: RTL and testbench



---
 rtl/jtframe_pkg.sv | 12 +
 rtl/jtframe_frac_cen.sv | 31 +++
 rtl/jtframe_rst_seq.sv | 126 ++++++++++++
 tb/tb_jtframe_rst_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jtframe_pkg.sv
// Shared types for the jtframe reset sequencer and related blocks.
package jtframe_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_SDRAM_INIT = 3'd2,
    ST_GAME_HOLD  = 3'd3,
    ST_RUN        = 3'd4
  } rst_st_e;

endpackage

// File: rtl/jtframe_frac_cen.sv
// Accumulator-based fractional clock enable: FRAC_N pulses every FRAC_M cycles while run=1.
module jtframe_frac_cen #(
  parameter int FRAC_N = 3,
  parameter int FRAC_M = 40,
  parameter int FW     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic cen
);

  logic [FW-1:0] acc;
  logic [FW-1:0] acc_nxt;

  assign acc_nxt = acc + FW'(FRAC_N);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (acc_nxt >= FW'(FRAC_M)) begin
      acc <= acc_nxt - FW'(FRAC_M);
      cen <= 1'b1;
    end else begin
      acc <= acc_nxt;
      cen <= 1'b0;
    end
  end

endmodule

// File: rtl/jtframe_rst_seq.sv
// PLL lock qualification, SDRAM-then-game reset sequencing and phase-aligned clock enables.
module jtframe_rst_seq
  import jtframe_pkg::*;
#(
  parameter int SETTLE    = 480,
  parameter int SDRAM_TMO = 19200,
  parameter int GAME_HOLD = 64,
  parameter int CW        = 16,
  parameter int FRAC_N    = 3,
  parameter int FRAC_M    = 40,
  parameter int FW        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic sdram_rdy,
  output logic rst_sdram,
  output logic rst_game,
  output logic cen24,
  output logic cen12,
  output logic cen6,
  output logic cen_frac,
  output logic init_err
);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(SDRAM_TMO - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(GAME_HOLD - 1);

  logic [1:0]    lk_pipe;
  logic          lk;
  rst_st_e       st;
  logic [CW-1:0] cnt;
  logic [2:0]    ph;
  logic          run;

  assign lk  = lk_pipe[1];
  // Enables freeze the same cycle a lost lock is seen, not one later
  assign run = (st != ST_WAIT_LOCK) && lk;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_pipe   <= '0;
      st        <= ST_WAIT_LOCK;
      cnt       <= '0;
      ph        <= '0;
      rst_sdram <= 1'b1;
      rst_game  <= 1'b1;
      init_err  <= 1'b0;
      cen24     <= 1'b0;
      cen12     <= 1'b0;
      cen6      <= 1'b0;
    end else begin
      lk_pipe <= {lk_pipe[0], pll_locked};
      cen24   <= run && ph[0];
      cen12   <= run && (ph[1:0] == 2'b11);
      cen6    <= run && (ph == 3'b111);
      ph      <= run ? ph + 3'd1 : 3'd0;
      cnt     <= cnt + 1'b1;
      if (st != ST_WAIT_LOCK && !lk) begin
        st        <= ST_WAIT_LOCK;
        rst_sdram <= 1'b1;
        rst_game  <= 1'b1;
        cnt       <= '0;
      end else begin
        case (st)
          ST_WAIT_LOCK: begin
            rst_sdram <= 1'b1;
            rst_game  <= 1'b1;
            cnt       <= '0;
            if (lk) begin
              st <= ST_SETTLE;
              ph <= '0;
            end
          end
          ST_SETTLE:
            if (cnt == SETTLE_LAST) begin
              st        <= ST_SDRAM_INIT;
              rst_sdram <= 1'b0;
              cnt       <= '0;
            end
          ST_SDRAM_INIT:
            if (sdram_rdy) begin
              st  <= ST_GAME_HOLD;
              cnt <= '0;
            end else if (cnt == TMO_LAST) begin
              // Retry: pulse the controller's reset again through a full settle period
              st        <= ST_SETTLE;
              init_err  <= 1'b1;
              rst_sdram <= 1'b1;
              cnt       <= '0;
              ph        <= '0;
            end
          ST_GAME_HOLD:
            if (!sdram_rdy) begin
              st  <= ST_SDRAM_INIT;
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              st       <= ST_RUN;
              rst_game <= 1'b0;
              cnt      <= '0;
            end
          ST_RUN: cnt <= '0;
          default: begin
            st        <= ST_WAIT_LOCK;
            rst_sdram <= 1'b1;
            rst_game  <= 1'b1;
            cnt       <= '0;
          end
        endcase
      end
    end
  end

  jtframe_frac_cen #(
    .FRAC_N(FRAC_N),
    .FRAC_M(FRAC_M),
    .FW    (FW)
  ) u_frac (
    .clk(clk),
    .rst(rst),
    .run(run),
    .cen(cen_frac)
  );

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Directed bench for jtframe_rst_seq with a queue of expected values checked as events occur.
module tb_jtframe_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic sdram_rdy = 1'b0;
  logic rst_sdram, rst_game, cen24, cen12, cen6, cen_frac, init_err;

  always #5 clk = ~clk;

  jtframe_rst_seq #(
    .SETTLE(4), .SDRAM_TMO(10), .GAME_HOLD(3)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .sdram_rdy(sdram_rdy),
    .rst_sdram(rst_sdram), .rst_game(rst_game), .cen24(cen24), .cen12(cen12),
    .cen6(cen6), .cen_frac(cen_frac), .init_err(init_err)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input int act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, act, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cen_any();
    return int'(cen24 | cen12 | cen6 | cen_frac);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_sd, f_gm, f_24, f_12, f_6, r_sd, ie, f2, gm3, cz3, n;
    int n24, n12, n6, nf, bad6, b2b, rg, prev, sd_hi;

    // Reset state
    rst = 1'b1;
    repeat (5) tick();
    push("reset_rst_sdram", 1); push("reset_rst_game", 1);
    push("reset_init_err", 0);  push("reset_cens", 0);
    chk(int'(rst_sdram)); chk(int'(rst_game)); chk(int'(init_err)); chk(cen_any());

    // Power-up with SDRAM ready immediately
    push("pwr_rst_sdram_fall", 7); push("pwr_rst_game_fall", 11);
    push("pwr_first_cen24", 5); push("pwr_first_cen12", 7); push("pwr_first_cen6", 11);
    push("pwr_init_err", 0);
    sdram_rdy = 1'b1; pll_locked = 1'b1; rst = 1'b0;
    f_sd = -1; f_gm = -1; f_24 = -1; f_12 = -1; f_6 = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (f_sd < 0 && !rst_sdram) f_sd = i;
      if (f_gm < 0 && !rst_game)  f_gm = i;
      if (f_24 < 0 && cen24) f_24 = i;
      if (f_12 < 0 && cen12) f_12 = i;
      if (f_6 < 0 && cen6)   f_6 = i;
    end
    chk(f_sd); chk(f_gm); chk(f_24); chk(f_12); chk(f_6); chk(int'(init_err));

    // Enable cadence in RUN; sdram_rdy is ignored here
    push("run_cen24_count", 400); push("run_cen12_count", 200); push("run_cen6_count", 100);
    push("run_cen_frac_count", 60); push("run_cen6_alignment", 0);
    push("run_cen_frac_back2back", 0); push("run_rst_game_high", 0);
    sdram_rdy = 1'b0;
    n24 = 0; n12 = 0; n6 = 0; nf = 0; bad6 = 0; b2b = 0; rg = 0; prev = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      n24 += int'(cen24); n12 += int'(cen12); n6 += int'(cen6); nf += int'(cen_frac);
      if (cen6 && !(cen12 && cen24)) bad6++;
      if (cen_frac && prev != 0) b2b++;
      prev = int'(cen_frac);
      rg += int'(rst_game);
    end
    chk(n24); chk(n12); chk(n6); chk(nf); chk(bad6); chk(b2b); chk(rg);

    // One-cycle lock glitch in RUN, then full resequence
    push("glitch_rst_sdram_rise", 3); push("glitch_rst_game_at3", 1); push("glitch_cens_at3", 0);
    push("glitch_rst_sdram_fall", 8); push("glitch_rst_game_fall", 12);
    sdram_rdy = 1'b1; pll_locked = 1'b0;
    r_sd = -1; f_sd = -1; f_gm = -1; gm3 = -1; cz3 = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) pll_locked = 1'b1;
      if (i == 3) begin gm3 = int'(rst_game); cz3 = cen_any(); end
      if (r_sd < 0 && rst_sdram) r_sd = i;
      if (r_sd >= 0 && i > r_sd && f_sd < 0 && !rst_sdram) f_sd = i;
      if (r_sd >= 0 && i > r_sd && f_gm < 0 && !rst_game) f_gm = i;
    end
    chk(r_sd); chk(gm3); chk(cz3); chk(f_sd); chk(f_gm);

    // SDRAM init timeout and retry
    push("tmo_waitlock_rst_sdram", 1);
    pll_locked = 1'b0; sdram_rdy = 1'b0;
    repeat (5) tick();
    chk(int'(rst_sdram));
    push("tmo_first_fall", 7); push("tmo_rst_sdram_rise", 17);
    push("tmo_init_err_set", 17); push("tmo_second_fall", 21);
    pll_locked = 1'b1;
    f_sd = -1; r_sd = -1; ie = -1; f2 = -1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (f_sd < 0 && !rst_sdram) f_sd = i;
      if (f_sd >= 0 && r_sd < 0 && rst_sdram) r_sd = i;
      if (r_sd >= 0 && i > r_sd && f2 < 0 && !rst_sdram) f2 = i;
      if (ie < 0 && init_err) ie = i;
    end
    chk(f_sd); chk(r_sd); chk(ie); chk(f2);
    push("tmo_game_fall_after_rdy", 4); push("tmo_init_err_sticky", 1);
    sdram_rdy = 1'b1;
    n = 0;
    while (rst_game !== 1'b0 && n < 50) begin tick(); n++; end
    if (n >= 50) n = -1;
    chk(n); chk(int'(init_err));

    // Synchronous reset in RUN
    push("rst_run_rst_sdram", 1); push("rst_run_rst_game", 1);
    push("rst_run_init_err", 0);  push("rst_run_cens", 0);
    rst = 1'b1;
    tick();
    chk(int'(rst_sdram)); chk(int'(rst_game)); chk(int'(init_err)); chk(cen_any());

    // sdram_rdy drop during GAME_HOLD
    push("gh_rst_sdram_fall", 7); push("gh_rst_game_after_drop", 1);
    push("gh_game_fall_after_reraise", 4); push("gh_rst_sdram_high", 0);
    sdram_rdy = 1'b1; rst = 1'b0;
    f_sd = -1; gm3 = -1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (f_sd < 0 && !rst_sdram) f_sd = i;
      if (i == 8) sdram_rdy = 1'b0;
      if (i == 9) begin gm3 = int'(rst_game); sdram_rdy = 1'b1; end
    end
    f_gm = -1; sd_hi = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      sd_hi += int'(rst_sdram);
      if (f_gm < 0 && !rst_game) f_gm = j;
    end
    chk(f_sd); chk(gm3); chk(f_gm); chk(sd_hi);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
